traffic_light_ctrl: RTL and testbench

- Two-road traffic light controller. Main road A rests green by default; side road B gets green on demand.
- The block owns the intersection phase FSM and the dwell timer.
- It drives the lamp outputs and the select line of the downstream 2:1 mux stage: sel=0 routes road-A data, sel=1 routes road-B data.
- Sits between the road sensors and the mux/lamp-driver datapath.

---
 rtl/traffic_light_ctrl.sv | 79 +++++++
 tb/tb_traffic_light_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road intersection phase FSM with dwell timer, lamp decode and mux select
module traffic_light_ctrl #(
    parameter int TW          = 4,
    parameter int T_GREEN_MIN = 4,
    parameter int T_GREEN_MAX = 12,
    parameter int T_YELLOW    = 2,
    parameter int T_ALLRED    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_b,
    input  logic       hold,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic       sel,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        A_GREEN    = 3'd0,
        A_YELLOW   = 3'd1,
        ALL_RED_AB = 3'd2,
        B_GREEN    = 3'd3,
        B_YELLOW   = 3'd4,
        ALL_RED_BA = 3'd5
    } state_t;

    localparam logic [TW-1:0] GMIN = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX = TW'(T_GREEN_MAX - 1);
    localparam logic [TW-1:0] YEND = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] REND = TW'(T_ALLRED - 1);

    state_t        state, nxt, cand;
    logic [TW-1:0] timer, nxt_timer;
    logic          pending_b, nxt_pend, dem_b, go, bad;

    // next-state, timer and pending-request logic; illegal codes escape to A_GREEN even under hold
    always_comb begin
        dem_b = pending_b | req_b;
        go    = 1'b0;
        bad   = 1'b0;
        cand  = A_GREEN;
        case (state)
            A_GREEN:    begin go = (timer >= GMIN) && dem_b; cand = A_YELLOW; end
            A_YELLOW:   begin go = timer == YEND; cand = ALL_RED_AB; end
            ALL_RED_AB: begin go = timer == REND; cand = B_GREEN; end
            B_GREEN:    begin go = (timer == GMAX) || ((timer >= GMIN) && !req_b); cand = B_YELLOW; end
            B_YELLOW:   begin go = timer == YEND; cand = ALL_RED_BA; end
            ALL_RED_BA: begin go = timer == REND; cand = A_GREEN; end
            default:    begin bad = 1'b1; cand = A_GREEN; end
        endcase
        nxt       = (bad || (go && !hold)) ? cand : state;
        nxt_timer = (bad || (go && !hold)) ? '0 :
                    hold ? timer :
                    (state == A_GREEN && timer >= GMIN) ? GMIN : timer + 1'b1;
        nxt_pend  = (nxt == B_GREEN && state != B_GREEN) ? 1'b0 :
                    (req_b && state != B_GREEN) ? 1'b1 : pending_b;
    end

    // state registers; lamps and select are registered from the next state so they track it exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= A_GREEN;
            timer     <= '0;
            pending_b <= 1'b0;
            light_a   <= 3'b001;
            light_b   <= 3'b100;
            sel       <= 1'b0;
        end else begin
            state     <= nxt;
            timer     <= nxt_timer;
            pending_b <= nxt_pend;
            light_a   <= nxt == A_GREEN ? 3'b001 : nxt == A_YELLOW ? 3'b010 : 3'b100;
            light_b   <= nxt == B_GREEN ? 3'b001 : nxt == B_YELLOW ? 3'b010 : 3'b100;
            sel       <= nxt == B_GREEN || nxt == B_YELLOW;
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed vector tables, multi-cycle corner sequences and a randomized model check
module tb_traffic_light_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_b = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] light_a, light_b, state_o;
    logic       sel;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic       req;
        logic       hld;
        logic [2:0] st;
    } vec_t;

    vec_t vec [20];
    logic [2:0] pulse_st [20] = '{0,0,0,0,1,1,2,3,3,3,3,4,4,5,0,0,0,0,0,0};

    traffic_light_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_b(req_b), .hold(hold),
        .light_a(light_a), .light_b(light_b), .sel(sel), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] expect_of(input logic [2:0] s);
        logic [2:0] la, lb;
        la = s == 3'd0 ? 3'b001 : s == 3'd1 ? 3'b010 : 3'b100;
        lb = s == 3'd3 ? 3'b001 : s == 3'd4 ? 3'b010 : 3'b100;
        return {s, la, lb, (s == 3'd3 || s == 3'd4)};
    endfunction

    task automatic chk(input string name, input int k, input logic [2:0] es);
        logic [9:0] got, exp;
        got = {state_o, light_a, light_b, sel};
        exp = expect_of(es);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got state=%0d A=%b B=%b sel=%b, want state=%0d A=%b B=%b sel=%b",
                     name, k, got[9:7], got[6:4], got[3:1], got[0], exp[9:7], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_b = 1'b0; hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [2:0] exp_held(input int k);
        return k < 4 ? 3'd0 : k < 6 ? 3'd1 : k < 7 ? 3'd2 : k < 19 ? 3'd3 :
               k < 21 ? 3'd4 : k < 22 ? 3'd5 : k < 26 ? 3'd0 : 3'd1;
    endfunction

    function automatic logic [2:0] exp_hold(input int k);
        return k < 4 ? 3'd0 : k < 11 ? 3'd1 : k < 12 ? 3'd2 : k < 16 ? 3'd3 :
               k < 18 ? 3'd4 : k < 19 ? 3'd5 : 3'd0;
    endfunction

    initial begin
        int st, tm, nst, ntm;
        logic pend, npend, go;
        for (int i = 0; i < 20; i++) vec[i] = '{(i == 1), 1'b0, pulse_st[i]};

        do_reset();
        chk("reset", 0, 3'd0);
        for (int k = 0; k < 20; k++) begin
            chk("idle", k, 3'd0);
            @(negedge clk);
        end

        do_reset();
        for (int k = 0; k < 20; k++) begin
            chk("pulse", k, vec[k].st);
            req_b = vec[k].req; hold = vec[k].hld;
            @(negedge clk);
        end

        do_reset();
        for (int k = 0; k < 27; k++) begin
            chk("held", k, exp_held(k));
            req_b = 1'b1;
            @(negedge clk);
        end

        do_reset();
        for (int k = 0; k < 23; k++) begin
            chk("hold", k, exp_hold(k));
            req_b = (k == 1);
            hold = (k >= 4 && k <= 8);
            @(negedge clk);
        end

        do_reset();
        for (int k = 0; k < 10; k++) begin
            chk("pre_rst", k, pulse_st[k]);
            req_b = (k == 1);
            rst_n = (k != 9);
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int k = 10; k < 20; k++) begin
            chk("mid_rst", k, 3'd0);
            @(negedge clk);
        end

        do_reset();
        st = 0; tm = 0; pend = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            chk("model", k, 3'(st));
            n_cmp++;
            if ((light_a != 3'b100 && light_b != 3'b100) || !$onehot(light_a) || !$onehot(light_b) ||
                (sel && state_o != 3'd3 && state_o != 3'd4)) begin
                n_bad++;
                $display("FAIL safety cycle %0d: got A=%b B=%b sel=%b state=%0d, want one red side, one-hot lamps, sel only in 3/4",
                         k, light_a, light_b, sel, state_o);
            end
            req_b = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 7) == 0);
            go = (st == 0 && tm >= 3 && (pend || req_b)) || (st == 1 && tm == 1) || (st == 2 && tm == 0) ||
                 (st == 3 && (tm == 11 || (tm >= 3 && !req_b))) || (st == 4 && tm == 1) || (st == 5 && tm == 0);
            nst = st; ntm = tm;
            if (!hold) begin
                if (go) begin nst = (st + 1) % 6; ntm = 0; end
                else ntm = (st == 0 && tm >= 3) ? 3 : tm + 1;
            end
            npend = (nst == 3 && st != 3) ? 1'b0 : (req_b && st != 3) ? 1'b1 : pend;
            st = nst; tm = ntm; pend = npend;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
